// File: rtl/bcd_time_counter_if.sv
// Control/status bundle for bcd_time_counter.
// Lap ports exist only when LAP_CAPTURE_EN is defined.
interface bcd_time_counter_if #(
  parameter int W = 16
);
  logic         i_enable;
  logic         i_up_down;
  logic         i_stop_at_limit;
  logic         i_clear;
  logic         i_load;
  logic [W-1:0] i_load_value;
  logic [W-1:0] o_count;
  logic         o_tick;
  logic         o_done;
`ifdef LAP_CAPTURE_EN
  logic         i_lap;
  logic [W-1:0] o_lap_count;
`endif

  modport master (
    output i_enable,
    output i_up_down,
    output i_stop_at_limit,
    output i_clear,
    output i_load,
    output i_load_value,
`ifdef LAP_CAPTURE_EN
    output i_lap,
    input  o_lap_count,
`endif
    input  o_count,
    input  o_tick,
    input  o_done
  );

  modport slave (
    input  i_enable,
    input  i_up_down,
    input  i_stop_at_limit,
    input  i_clear,
    input  i_load,
    input  i_load_value,
`ifdef LAP_CAPTURE_EN
    input  i_lap,
    output o_lap_count,
`endif
    output o_count,
    output o_tick,
    output o_done
  );
endinterface

// File: rtl/bcd_time_counter.sv
// Multi-digit BCD time counter with prescaler, load/clear, stop-or-wrap.
// Optional LAP_CAPTURE_EN adds a lap snapshot register.
module bcd_time_counter #(
  parameter int                      NUM_DIGITS  = 4,
  parameter logic [4*NUM_DIGITS-1:0] DIGIT_BASES = 16'h6A6A,
  parameter int                      TICK_DIV    = 100_000_000
) (
  input  logic            i_clk,
  input  logic            i_rst,
  bcd_time_counter_if.slave bus
);
  localparam int W  = 4 * NUM_DIGITS;
  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PLAST = PW'(TICK_DIV - 1);

  logic [W-1:0]  r_count;
  logic [PW-1:0] r_presc;
  logic          r_tick;
  logic          r_done;

  logic [W-1:0]  w_clamp;
  logic [W-1:0]  w_up;
  logic [W-1:0]  w_dn;
  logic [W-1:0]  w_max;
  logic [W-1:0]  w_next;
  logic [W-1:0]  w_lim;
  logic          w_at_lim;
  logic          w_step_req;
  logic          w_do_step;

  // Full-width ripple: a digit moves when all lower digits sit at their edge.
  always_comb begin
    logic       cu;
    logic       cd;
    logic [3:0] b;
    logic [3:0] d;
    logic [3:0] lv;
    w_clamp = '0;
    w_up    = '0;
    w_dn    = '0;
    w_max   = '0;
    cu      = 1'b1;
    cd      = 1'b1;
    b       = '0;
    d       = '0;
    lv      = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      b  = DIGIT_BASES[4*i +: 4];
      d  = r_count[4*i +: 4];
      lv = bus.i_load_value[4*i +: 4];
      w_max[4*i +: 4]   = b - 4'd1;
      w_clamp[4*i +: 4] = (lv >= b) ? b - 4'd1 : lv;
      if (cu) begin
        w_up[4*i +: 4] = (d == b - 4'd1) ? 4'd0 : d + 4'd1;
        cu = (d == b - 4'd1);
      end else begin
        w_up[4*i +: 4] = d;
      end
      if (cd) begin
        w_dn[4*i +: 4] = (d == 4'd0) ? b - 4'd1 : d - 4'd1;
        cd = (d == 4'd0);
      end else begin
        w_dn[4*i +: 4] = d;
      end
    end
  end

  assign w_next     = bus.i_up_down ? w_up : w_dn;
  assign w_lim      = bus.i_up_down ? w_max : '0;
  assign w_at_lim   = (r_count == w_lim);
  assign w_step_req = bus.i_enable && (r_presc == PLAST);
  assign w_do_step  = w_step_req && !(w_at_lim && bus.i_stop_at_limit);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_count <= '0;
      r_presc <= '0;
      r_tick  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_tick <= 1'b0;
      r_done <= 1'b0;
      if (bus.i_clear) begin
        r_count <= '0;
        r_presc <= '0;
      end else if (bus.i_load) begin
        r_count <= w_clamp;
        r_presc <= '0;
      end else begin
        if (bus.i_enable)
          r_presc <= w_step_req ? '0 : r_presc + PW'(1);
        if (w_do_step) begin
          r_count <= w_next;
          r_tick  <= 1'b1;
          r_done  <= (w_next == w_lim);
        end
      end
    end
  end

`ifdef LAP_CAPTURE_EN
  logic [W-1:0] r_lap_count;

  // Registered from r_count, so a same-cycle step yields the pre-step value.
  always_ff @(posedge i_clk) begin
    if (i_rst || bus.i_clear)
      r_lap_count <= '0;
    else if (bus.i_lap)
      r_lap_count <= r_count;
  end

  assign bus.o_lap_count = r_lap_count;
`endif

  assign bus.o_count = r_count;
  assign bus.o_tick  = r_tick;
  assign bus.o_done  = r_done;
endmodule

// File: tb/tb_bcd_time_counter.sv
// Scoreboard bench for bcd_time_counter (TICK_DIV=4, bases 6A6A).
// Stimulus pushes expected steps; a negedge monitor pops on each tick.
module tb_bcd_time_counter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;
  logic [16:0] sb_q[$];

  always #5 clk = ~clk;

  bcd_time_counter_if #(.W(16)) bus ();

  bcd_time_counter #(
    .NUM_DIGITS (4),
    .DIGIT_BASES(16'h6A6A),
    .TICK_DIV   (4)
  ) dut (
    .i_clk(clk),
    .i_rst(rst),
    .bus  (bus)
  );

  task automatic chk(input string n, input logic [15:0] act,
                     input logic [15:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", n, act, req);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [15:0] c, input logic d);
    sb_q.push_back({c, d});
  endtask

  task automatic do_load(input logic [15:0] v);
    bus.i_load       = 1'b1;
    bus.i_load_value = v;
    cyc();
    bus.i_load = 1'b0;
  endtask

  // One full enabled prescaler period from prescaler 0.
  task automatic window();
    bus.i_enable = 1'b1;
    repeat (4) cyc();
    bus.i_enable = 1'b0;
  endtask

  task automatic step_exp(input logic [15:0] c, input logic d);
    push(c, d);
    window();
  endtask

  always @(negedge clk) begin
    logic [16:0] e;
    if (bus.o_tick === 1'b1) begin
      if (sb_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_tick actual=%h required=no_step",
                 bus.o_count);
      end else begin
        e = sb_q.pop_front();
        chk("step_count", bus.o_count, e[16:1]);
        chk("step_done", {15'b0, bus.o_done}, {15'b0, e[0]});
      end
    end else if (bus.o_done === 1'b1) begin
      total++;
      bad++;
      $display("FAIL done_without_tick actual=1 required=0");
    end
  end

  initial begin
    bus.i_enable        = 1'b0;
    bus.i_up_down       = 1'b1;
    bus.i_stop_at_limit = 1'b0;
    bus.i_clear         = 1'b0;
    bus.i_load          = 1'b0;
    bus.i_load_value    = '0;
`ifdef LAP_CAPTURE_EN
    bus.i_lap           = 1'b0;
`endif
    rst = 1'b1;
    repeat (2) cyc();
    rst = 1'b0;
    chk("rst_count", bus.o_count, 16'h0000);
    chk("rst_tick", {15'b0, bus.o_tick}, 16'h0);
    chk("rst_done", {15'b0, bus.o_done}, 16'h0);

    // first step lands after exactly 4 enabled cycles
    push(16'h0001, 1'b0);
    bus.i_enable = 1'b1;
    repeat (3) cyc();
    chk("pre_first_step", bus.o_count, 16'h0000);
    cyc();
    push(16'h0002, 1'b0);
    repeat (3) cyc();
    chk("pre_second_step", bus.o_count, 16'h0001);
    cyc();
    bus.i_enable = 1'b0;

    // up ripple and limit
    do_load(16'h0959);
    step_exp(16'h1000, 1'b0);
    do_load(16'h5958);
    step_exp(16'h5959, 1'b1);
    step_exp(16'h0000, 1'b0);
    do_load(16'h5958);
    step_exp(16'h5959, 1'b1);
    bus.i_stop_at_limit = 1'b1;
    window();
    chk("hold_up_count", bus.o_count, 16'h5959);
    chk("hold_up_tick", {15'b0, bus.o_tick}, 16'h0);

    // down ripple and limit
    bus.i_up_down       = 1'b0;
    bus.i_stop_at_limit = 1'b0;
    do_load(16'h0100);
    step_exp(16'h0059, 1'b0);
    do_load(16'h0001);
    step_exp(16'h0000, 1'b1);
    step_exp(16'h5959, 1'b0);
    bus.i_stop_at_limit = 1'b1;
    do_load(16'h0000);
    window();
    chk("hold_dn_count", bus.o_count, 16'h0000);
    bus.i_stop_at_limit = 1'b0;

    // load clamp
    do_load(16'hF9C7);
    chk("clamp", bus.o_count, 16'h5957);

    // clear beats load
    bus.i_clear = 1'b1;
    do_load(16'h1234);
    bus.i_clear = 1'b0;
    chk("clear_over_load", bus.o_count, 16'h0000);

    // load wins over a step request
    bus.i_up_down = 1'b1;
    bus.i_enable  = 1'b1;
    repeat (3) cyc();
    do_load(16'h0042);
    bus.i_enable = 1'b0;
    chk("load_over_step", bus.o_count, 16'h0042);
    chk("load_over_step_tick", {15'b0, bus.o_tick}, 16'h0);

    // pause holds the prescaler
    bus.i_enable = 1'b1;
    repeat (2) cyc();
    bus.i_enable = 1'b0;
    repeat (10) cyc();
    chk("paused", bus.o_count, 16'h0042);
    push(16'h0043, 1'b0);
    bus.i_enable = 1'b1;
    cyc();
    chk("resume_pre", bus.o_count, 16'h0042);
    cyc();
    bus.i_enable = 1'b0;
    chk("resume_step", bus.o_count, 16'h0043);

`ifdef LAP_CAPTURE_EN
    do_load(16'h0012);
    bus.i_enable = 1'b1;
    repeat (3) cyc();
    bus.i_lap = 1'b1;
    push(16'h0013, 1'b0);
    cyc();
    bus.i_lap    = 1'b0;
    bus.i_enable = 1'b0;
    chk("lap_capture", bus.o_lap_count, 16'h0012);
    chk("lap_count_after", bus.o_count, 16'h0013);
    do_load(16'h0500);
    chk("lap_load_keep", bus.o_lap_count, 16'h0012);
    bus.i_clear = 1'b1;
    cyc();
    bus.i_clear = 1'b0;
    chk("lap_clear", bus.o_lap_count, 16'h0000);
`endif

    repeat (2) cyc();
    chk("sb_drain", 16'(sb_q.size()), 16'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/bcd_time_counter.md
Name: bcd_time_counter

Overview:
Parametrised multi-digit BCD time counter for the stopwatch/timer display path. It is the generalised successor of the fixed 4-digit MM:SS counter, and adds:
- configurable digit count and per-digit base
- internal tick prescaler
- enable/pause, synchronous load and clear
- limit detection with selectable stop-or-wrap behaviour
The registered count feeds the seven-segment display driver directly.

Parameters:
NUM_DIGITS, 4, number of 4-bit BCD digits; digit 0 is the least significant.
DIGIT_BASES, 16'h6A6A, packed 4-bit base per digit, digit i in bits [4i+3:4i]; legal values 2..15; default gives M10=6, M1=10, S10=6, S1=10.
TICK_DIV, 100_000_000, clk cycles per count step; 100 MHz board clock gives 1 s; must be >= 1.

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
enable  in  1  1 = run the prescaler and step; 0 = pause with the prescaler value held
up_down  in  1  1 = count up, 0 = count down
stop_at_limit  in  1  1 = hold at the limit value, 0 = wrap past it
clear  in  1  synchronous clear of the count and prescaler
load  in  1  synchronous load of load_value
load_value  in  4*NUM_DIGITS  BCD value to load
count  out  4*NUM_DIGITS  registered BCD count
tick  out  1  1-cycle pulse in the cycle after a step changed count
done  out  1  1-cycle pulse when a step lands count on the limit value

Behaviour:
- rst: count=0, prescaler=0, tick=0, done=0. Reset takes effect on the clock edge it is sampled.
- Priority, highest first: rst > clear > load > step.
- clear: count=0 and prescaler=0.
- load:
  - count = load_value, with each digit >= its base clamped to base-1.
  - prescaler=0.
  - tick and done stay 0 in a load or clear cycle.
- Prescaler:
  - Counts 0..TICK_DIV-1 while enable=1, then wraps to 0; holds while enable=0.
  - A step request occurs in the cycle where enable=1 and prescaler==TICK_DIV-1.
  - The first step after reset therefore lands TICK_DIV enabled cycles later.
- Limit value: all digits at base-1 when up_down=1; all digits 0 when up_down=0.
- Step, up:
  - Digit i increments if every lower digit equals base-1; a digit at base-1 that increments wraps to 0.
  - The whole ripple resolves in one cycle, with no per-digit pipelining.
- Step, down:
  - Digit i decrements if every lower digit equals 0; a digit at 0 that decrements wraps to base-1.
- At limit with stop_at_limit=1: the step is suppressed, count is unchanged, tick=0, done=0. The prescaler keeps running.
- At limit with stop_at_limit=0: the step wraps, giving all 0 (up) or all base-1 (down). tick=1.
- tick and done timing:
  - tick and done are registered on the same edge as count, so they are visible in the same cycle as the new count.
  - done=1 only when a performed step produces the limit value. A load of the limit value does not assert done.
- up_down and stop_at_limit are sampled at each step; a change mid-run takes effect on the next step with no count glitch.
- Outputs are all registers; there is no combinational path from the inputs to the outputs.

Optional Feature:
LAP_CAPTURE_EN:
- Defined: adds input lap (1 bit) and output lap_count (4*NUM_DIGITS).
  - A lap=1 cycle captures the current count into lap_count on the next edge.
  - If a step happens in the same cycle, the pre-step value is captured.
  - rst and clear zero lap_count; load does not affect it.
- Undefined: the lap and lap_count ports and their logic are absent.

Test Plan (TICK_DIV=4, default bases):
1. Reset and first step: rst 2 cycles -> count=0000, tick=0, done=0. Then enable=1, up -> count=0001 with tick=1 after exactly 4 cycles, and every 4 cycles after that.
2. Up ripple and limit:
   - load 16'h0959, step -> 1000.
   - load 5958, step -> 5959 with done=1 for 1 cycle.
   - Next step with stop_at_limit=0 -> 0000, tick=1, done=0.
   - Repeat with stop_at_limit=1 -> holds at 5959, tick=0.
3. Down ripple and limit:
   - load 0100, up_down=0, step -> 0059.
   - load 0001, step -> 0000 with done=1.
   - stop_at_limit=0, step -> 5959.
4. Load clamp: load_value 16'hF9C7 -> count=5957.
5. Priority and pause:
   - clear and load in the same cycle -> 0000.
   - load in a step-request cycle -> load value, tick=0.
   - enable=0 after 2 prescaler cycles, hold 10 cycles, re-enable -> step occurs after 2 more cycles.
6. With LAP_CAPTURE_EN: count=0012 with a step pending, pulse lap -> lap_count=0012, count=0013; clear -> lap_count=0000.
